// File: rtl/trainer_dip_debounce_pkg.sv
// Shared defaults for the trainer DIP switch conditioning block.
package trainer_dip_debounce_pkg;

    localparam int DIP_WIDTH         = 8;
    localparam int DIP_CNT_BITS      = 16;
    localparam int CLK_HZ            = 50_000_000;
    localparam int DIP_STABLE_CYCLES = 50_000;

    // Each bit either agrees with its stable value or is counting a mismatch.
    typedef enum logic {
        DIP_IDLE     = 1'b0,
        DIP_COUNTING = 1'b1
    } dip_bit_state_e;

    function automatic int ms_to_cycles(input int ms);
        return (CLK_HZ / 1000) * ms;
    endfunction

endpackage

// File: rtl/dip_debounce_bit.sv
// One switch bit: two-flop synchroniser, stability counter, stable flop and edge pulses.
module dip_debounce_bit
    import trainer_dip_debounce_pkg::*;
#(
    parameter int STABLE_CYCLES = DIP_STABLE_CYCLES,
    parameter int CNT_BITS      = DIP_CNT_BITS
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic stable,
    output logic rise,
    output logic fall,
    output logic upd
);

    localparam logic [CNT_BITS-1:0] LAST = CNT_BITS'(STABLE_CYCLES - 1);

    logic                s1;
    logic                s2;
    logic [CNT_BITS-1:0] cnt;
    dip_bit_state_e      state;

    assign state = (s2 == stable) ? DIP_IDLE : DIP_COUNTING;
    // Acceptance happens on the edge where the mismatch run reaches its full length.
    assign upd   = (state == DIP_COUNTING) && (cnt == LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            s1     <= 1'b0;
            s2     <= 1'b0;
            cnt    <= '0;
            stable <= 1'b0;
            rise   <= 1'b0;
            fall   <= 1'b0;
        end else begin
            s1   <= raw;
            s2   <= s1;
            rise <= 1'b0;
            fall <= 1'b0;
            case (state)
                DIP_IDLE: cnt <= '0;
                DIP_COUNTING: begin
                    if (upd) begin
                        stable <= s2;
                        cnt    <= '0;
                        rise   <= s2;
                        fall   <= ~s2;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: cnt <= '0;
            endcase
        end
    end

endmodule

// File: rtl/trainer_dip_debounce.sv
// Debounced trainer DIP switch bank with per-bit edge pulses and aggregate change flag.
// Define DIP_CHANGE_STICKY_EN to make dip_changed hold until dip_ack.
module trainer_dip_debounce
    import trainer_dip_debounce_pkg::*;
#(
    parameter int WIDTH         = DIP_WIDTH,
    parameter int STABLE_CYCLES = DIP_STABLE_CYCLES,
    parameter int CNT_BITS      = DIP_CNT_BITS
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] trainer_dip,
    output logic [WIDTH-1:0] dip_stable,
    output logic [WIDTH-1:0] dip_rise,
    output logic [WIDTH-1:0] dip_fall,
    output logic             dip_changed,
    input  logic             dip_ack
);

    logic [WIDTH-1:0] upd;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        dip_debounce_bit #(
            .STABLE_CYCLES(STABLE_CYCLES),
            .CNT_BITS     (CNT_BITS)
        ) u_bit (
            .clk   (clk),
            .rst   (rst),
            .raw   (trainer_dip[i]),
            .stable(dip_stable[i]),
            .rise  (dip_rise[i]),
            .fall  (dip_fall[i]),
            .upd   (upd[i])
        );
    end

    // Driven from the same update strobe as the pulses so it lines up with them.
`ifdef DIP_CHANGE_STICKY_EN
    always_ff @(posedge clk) begin
        if (rst)          dip_changed <= 1'b0;
        else if (|upd)    dip_changed <= 1'b1;
        else if (dip_ack) dip_changed <= 1'b0;
    end
`else
    logic unused_ack;
    assign unused_ack = dip_ack;

    always_ff @(posedge clk) begin
        if (rst) dip_changed <= 1'b0;
        else     dip_changed <= |upd;
    end
`endif

endmodule

// File: tb/tb_trainer_dip_debounce.sv
// Randomised and directed bench for trainer_dip_debounce against a sliding-window model.
module tb_trainer_dip_debounce;

    localparam int W = 8;
    localparam int N = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         dip_ack = 1'b0;
    logic [W-1:0] trainer_dip = '0;
    logic [W-1:0] dip_stable, dip_rise, dip_fall;
    logic         dip_changed;

    trainer_dip_debounce #(.WIDTH(W), .STABLE_CYCLES(N), .CNT_BITS(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .trainer_dip(trainer_dip),
        .dip_stable (dip_stable),
        .dip_rise   (dip_rise),
        .dip_fall   (dip_fall),
        .dip_changed(dip_changed),
        .dip_ack    (dip_ack)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    endtask

    // Reference: a bit is accepted once the synchronised value seen on the
    // last N clock edges has disagreed with the current stable value every time.
    logic [W-1:0] m_s1 = '0, m_s2 = '0, m_stable = '0, m_rise = '0, m_fall = '0;
    logic         m_chg = 1'b0;
    logic [W-1:0] hist[$];

    task automatic model_edge(input logic [W-1:0] d, input logic r, input logic a);
        logic [W-1:0] flip;
        bit           all_diff;
        flip = '0;
        if (r) begin
            m_s1 = '0; m_s2 = '0; m_stable = '0; m_rise = '0; m_fall = '0; m_chg = 1'b0;
            hist.delete();
        end else begin
            hist.push_back(m_s2);
            if (hist.size() > N) void'(hist.pop_front());
            if (hist.size() == N) begin
                for (int i = 0; i < W; i++) begin
                    all_diff = 1'b1;
                    foreach (hist[j]) if (hist[j][i] == m_stable[i]) all_diff = 1'b0;
                    flip[i] = all_diff;
                end
            end
            m_rise   = flip & ~m_stable;
            m_fall   = flip & m_stable;
            m_stable = m_stable ^ flip;
`ifdef DIP_CHANGE_STICKY_EN
            m_chg = (|flip) ? 1'b1 : (a ? 1'b0 : m_chg);
`else
            m_chg = |flip;
`endif
            m_s2 = m_s1;
            m_s1 = d;
        end
    endtask

    task automatic step(input logic [W-1:0] d, input logic r, input logic a);
        @(negedge clk);
        trainer_dip = d; rst = r; dip_ack = a;
        @(posedge clk);
        model_edge(d, r, a);
        #1;
        chk("stable",  dip_stable,  m_stable);
        chk("rise",    dip_rise,    m_rise);
        chk("fall",    dip_fall,    m_fall);
        chk("changed", dip_changed, m_chg);
    endtask

    logic [W-1:0] rnd_dip;

    initial begin
        // Reset hold with all switches on, then release.
        for (int i = 0; i < 3; i++) step(8'hFF, 1'b1, 1'b0);
        chk("t1_rst_stable", dip_stable, 8'h00);
        chk("t1_rst_rise", dip_rise, 8'h00);
        for (int i = 1; i <= 5; i++) step(8'hFF, 1'b0, 1'b0);
        chk("t1_early", dip_stable, 8'h00);
        step(8'hFF, 1'b0, 1'b0);
        chk("t1_stable", dip_stable, 8'hFF);
        chk("t1_rise", dip_rise, 8'hFF);
        chk("t1_changed", dip_changed, 1'b1);
        step(8'hFF, 1'b0, 1'b0);
        chk("t1_rise_end", dip_rise, 8'h00);

        // Glitch shorter than the window.
        for (int i = 0; i < 10; i++) step(8'h00, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++)  step(8'h01, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++)  step(8'h00, 1'b0, 1'b0);
        chk("t2_stable", dip_stable, 8'h00);

        // Bounce on bit3 while bits 0-2 switch cleanly.
        step(8'h0F, 1'b0, 1'b0); step(8'h07, 1'b0, 1'b0);
        for (int i = 3; i <= 5; i++) step(8'h0F, 1'b0, 1'b0);
        step(8'h0F, 1'b0, 1'b0);
        chk("t3_low_bits", dip_stable, 8'h07);
        chk("t3_low_rise", dip_rise, 8'h07);
        step(8'h0F, 1'b0, 1'b0);
        step(8'h0F, 1'b0, 1'b0);
        chk("t3_bit3", dip_stable, 8'h0F);
        chk("t3_bit3_rise", dip_rise, 8'h08);

        // Falling edge on bit7.
        for (int i = 0; i < 10; i++) step(8'h8F, 1'b0, 1'b0);
        for (int i = 1; i <= 6; i++) step(8'h0F, 1'b0, 1'b0);
        chk("t4_stable", dip_stable, 8'h0F);
        chk("t4_fall", dip_fall, 8'h80);
        chk("t4_rise", dip_rise, 8'h00);

        // Reset in the middle of a count discards progress.
        for (int i = 0; i < 10; i++) step(8'h00, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++)  step(8'h01, 1'b0, 1'b0);
        step(8'h01, 1'b1, 1'b0);
        for (int i = 1; i <= 5; i++) step(8'h01, 1'b0, 1'b0);
        chk("t5_early", dip_stable, 8'h00);
        step(8'h01, 1'b0, 1'b0);
        chk("t5_stable", dip_stable, 8'h01);

`ifdef DIP_CHANGE_STICKY_EN
        // Sticky change flag, ack clear and ack colliding with a new change.
        for (int i = 0; i < 10; i++) step(8'h00, 1'b0, 1'b1);
        for (int i = 1; i <= 6; i++) step(8'h01, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            step(8'h01, 1'b0, 1'b0);
            chk("t6_hold", dip_changed, 1'b1);
        end
        step(8'h01, 1'b0, 1'b1);
        chk("t6_ack", dip_changed, 1'b0);
        for (int i = 1; i <= 5; i++) step(8'h00, 1'b0, 1'b0);
        step(8'h00, 1'b0, 1'b1);
        chk("t6_ack_vs_set", dip_changed, 1'b1);
`endif

        // Random slow toggling with occasional ack and reset.
        rnd_dip = 8'h00;
        for (int i = 0; i < 600; i++) begin
            for (int b = 0; b < W; b++)
                if ($urandom_range(0, 9) == 0) rnd_dip[b] = ~rnd_dip[b];
            step(rnd_dip, ($urandom_range(0, 149) == 0), ($urandom_range(0, 5) == 0));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
